// File: rtl/cacheline_arb_pkg.sv
// Shared types and constants for the two-port cacheline arbiter.
// Holds the FSM state and grant-side enums, the bus widths, and a line-align helper.
// Optional round-robin arbitration is selected by the CACHELINE_ARB_RR_EN macro (see cacheline_arbiter).
package cacheline_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    // Clear the low 'off' bits so memory always sees a line-aligned address.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr,
                                                     input int                off);
        logic [ADDR_W-1:0] mask;
        mask = '1 << off;
        return addr & mask;
    endfunction

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory signals around the arbiter.
// Ports: i_* (I-side read), d_* (D-side read/write), pmem_* (memory side), arb_error.
// slave = arbiter view, master = environment view (caches + memory); CACHELINE_ARB_RR_EN does not change it.
interface cacheline_arbiter_if;
    import cacheline_arb_pkg::*;

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              pmem_error;

    logic              arb_error;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp, pmem_error,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata, arb_error
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp, pmem_error,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata, arb_error
    );

endinterface

// File: rtl/arb_watchdog.sv
// Counts grant cycles and flags a transaction that has waited TIMEOUT cycles for memory.
// Ports: clk, rst (sync, active-high), start (clear on grant), busy (in GRANT_x), expired (comb).
// expired is high during the TIMEOUT-th busy cycle so the FSM leaves on that edge.
module arb_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    output logic expired
);

    localparam int            CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // r_cnt holds (grant cycles elapsed - 1) during a grant; saturates at LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (busy && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = busy && (r_cnt == LIMIT);

endmodule

// File: rtl/cacheline_arbiter.sv
// Arbitrates one 256-bit physical memory port between I-cache reads and D-cache reads/writes.
// Ports: clk, rst (sync, active-high), bus (cacheline_arbiter_if.slave). Params TIMEOUT, OFFSET.
// Grant 1 cycle after request, resp passes through combinationally, then DONE + IDLE turnaround; CACHELINE_ARB_RR_EN selects round-robin ties.
module cacheline_arbiter
    import cacheline_arb_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int OFFSET  = 5
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_arbiter_if.slave  bus
);

    arb_state_e        r_state;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic              r_arb_error;

    logic  w_i_req;
    logic  w_d_req;
    logic  w_start;
    logic  w_busy;
    logic  w_expired;
    side_e w_win;

`ifdef CACHELINE_ARB_RR_EN
    side_e r_last_grant;
`endif

    assign w_i_req = bus.i_read;
    assign w_d_req = bus.d_read | bus.d_write;
    assign w_start = (r_state == IDLE) && (w_i_req || w_d_req);
    assign w_busy  = (r_state == GRANT_I) || (r_state == GRANT_D);

    // D wins ties unless round-robin is enabled and D was granted last.
    always_comb begin
        w_win = SIDE_D;
        if (w_i_req && !w_d_req) begin
            w_win = SIDE_I;
        end
`ifdef CACHELINE_ARB_RR_EN
        else if (w_i_req && w_d_req && (r_last_grant == SIDE_D)) begin
            w_win = SIDE_I;
        end
`endif
    end

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .busy    (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_arb_error    <= 1'b0;
`ifdef CACHELINE_ARB_RR_EN
            r_last_grant   <= SIDE_I;
`endif
        end else begin
            // A response arriving in the expiry cycle still completes normally.
            r_arb_error <= r_arb_error | bus.pmem_error | (w_expired & ~bus.pmem_resp);
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (w_win == SIDE_D) begin
                            r_state        <= GRANT_D;
                            // read+write together is a write
                            r_pmem_write   <= bus.d_write;
                            r_pmem_read    <= ~bus.d_write;
                            r_pmem_address <= line_align(bus.d_address, OFFSET);
                            r_pmem_wdata   <= bus.d_wdata;
                        end else begin
                            r_state        <= GRANT_I;
                            r_pmem_write   <= 1'b0;
                            r_pmem_read    <= 1'b1;
                            r_pmem_address <= line_align(bus.i_address, OFFSET);
                        end
`ifdef CACHELINE_ARB_RR_EN
                        r_last_grant <= w_win;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (bus.pmem_resp || w_expired) begin
                        r_state      <= DONE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_pmem_address;
    assign bus.pmem_wdata   = r_pmem_wdata;
    assign bus.arb_error    = r_arb_error;

    // Read data is shared; only the matching resp qualifies it.
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;
    // A reset in the final grant cycle cancels the response.
    assign bus.i_resp  = (r_state == GRANT_I) && bus.pmem_resp && !rst;
    assign bus.d_resp  = (r_state == GRANT_D) && bus.pmem_resp && !rst;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter (TIMEOUT=8, OFFSET=5).
// Ports: drives the master side of cacheline_arbiter_if; clk period 10.
// Expectations follow CACHELINE_ARB_RR_EN when it is defined for the build.
module tb_cacheline_arbiter;
    import cacheline_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_arbiter_if bus();

    cacheline_arbiter #(.TIMEOUT(8), .OFFSET(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [255:0] line_r1;
        logic [255:0] line_aa;
        logic [255:0] line_55;
        logic [255:0] line_r2;
        logic         rr;

        line_r1 = {8{32'hDEAD_BEEF}};
        line_aa = {32{8'hAA}};
        line_55 = {64{4'h5}};
        line_r2 = {8{32'h0123_4567}};
`ifdef CACHELINE_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        rst            = 1'b1;
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_error = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_pmem_read",  bus.pmem_read,    0);
        chk("rst_pmem_write", bus.pmem_write,   0);
        chk("rst_i_resp",     bus.i_resp,       0);
        chk("rst_d_resp",     bus.d_resp,       0);
        chk("rst_arb_error",  bus.arb_error,    0);
        chk("rst_address",    bus.pmem_address, 0);
        chk("rst_wdata",      bus.pmem_wdata,   0);

        // Single I read of 0x64, address changed mid-grant
        bus.i_address = 32'h0000_0064;
        bus.i_read    = 1'b1;
        tick();
        chk("t1_read_n1",  bus.pmem_read,    1);
        chk("t1_write_n1", bus.pmem_write,   0);
        chk("t1_addr_n1",  bus.pmem_address, 32'h0000_0060);
        bus.i_address = 32'h0000_1234;
        tick();
        chk("t1_addr_held", bus.pmem_address, 32'h0000_0060);
        chk("t1_read_held", bus.pmem_read,    1);
        chk("t1_no_resp",   bus.i_resp,       0);
        bus.pmem_rdata = line_r1;
        bus.pmem_resp  = 1'b1;
        #1;
        chk("t1_i_resp",  bus.i_resp,  1);
        chk("t1_d_resp",  bus.d_resp,  0);
        chk("t1_i_rdata", bus.i_rdata, line_r1);
        tick();
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        chk("t1_done_read", bus.pmem_read, 0);
        chk("t1_done_resp", bus.i_resp,    0);
        tick();
        chk("t1_idle_read", bus.pmem_read, 0);

        // Tie: I read 0x100 vs D write 0x200 -> D first
        bus.i_address = 32'h0000_0100;
        bus.i_read    = 1'b1;
        bus.d_address = 32'h0000_0200;
        bus.d_wdata   = line_aa;
        bus.d_write   = 1'b1;
        tick();
        chk("t2_write",  bus.pmem_write,   1);
        chk("t2_read",   bus.pmem_read,    0);
        chk("t2_addr",   bus.pmem_address, 32'h0000_0200);
        chk("t2_wdata",  bus.pmem_wdata,   line_aa);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t2_d_resp", bus.d_resp, 1);
        chk("t2_i_resp", bus.i_resp, 0);
        tick();
        // DONE: both commands low; D now asks for a read at 0x300, I still waiting
        bus.pmem_resp = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0300;
        chk("t2_done_write", bus.pmem_write, 0);
        chk("t2_done_read",  bus.pmem_read,  0);
        tick();
        chk("t2_idle_read",  bus.pmem_read,  0);
        tick();
        // Second tie: fixed priority keeps D, round-robin gives I
        chk("t3_read",  bus.pmem_read,    1);
        chk("t3_write", bus.pmem_write,   0);
        chk("t3_addr",  bus.pmem_address, rr ? 32'h0000_0100 : 32'h0000_0300);
        bus.pmem_rdata = line_r2;
        bus.pmem_resp  = 1'b1;
        #1;
        chk("t3_i_resp", bus.i_resp, rr ? 1 : 0);
        chk("t3_d_resp", bus.d_resp, rr ? 0 : 1);
        chk("t3_d_rdata", bus.d_rdata, line_r2);
        tick();
        bus.pmem_resp = 1'b0;
        if (rr) bus.i_read = 1'b0;
        else    bus.d_read = 1'b0;
        tick();
        tick();
        chk("t4_addr", bus.pmem_address, rr ? 32'h0000_0300 : 32'h0000_0100);
        chk("t4_read", bus.pmem_read,    1);
        bus.pmem_resp = 1'b1;
        #1;
        chk("t4_i_resp", bus.i_resp, rr ? 0 : 1);
        chk("t4_d_resp", bus.d_resp, rr ? 1 : 0);
        tick();
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        bus.d_read    = 1'b0;
        tick();

        // Watchdog: memory never responds to I read at 0x500
        bus.i_address = 32'h0000_0500;
        bus.i_read    = 1'b1;
        tick();
        chk("wd_read_g1", bus.pmem_read, 1);
        repeat (7) tick();
        chk("wd_err_g8",  bus.arb_error, 0);
        chk("wd_read_g8", bus.pmem_read, 1);
        tick();
        chk("wd_err_set",  bus.arb_error, 1);
        chk("wd_read_off", bus.pmem_read, 0);
        chk("wd_no_iresp", bus.i_resp,    0);
        bus.i_read = 1'b0;
        tick();
        tick();
        chk("wd_idle_read", bus.pmem_read, 0);
        chk("wd_err_stuck", bus.arb_error, 1);

        // Reset 3 cycles into a D write
        bus.d_address = 32'h0000_0600;
        bus.d_wdata   = line_55;
        bus.d_write   = 1'b1;
        tick();
        chk("rw_write_g1", bus.pmem_write, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        bus.d_write = 1'b0;
        chk("rw_write", bus.pmem_write,   0);
        chk("rw_read",  bus.pmem_read,    0);
        chk("rw_addr",  bus.pmem_address, 0);
        chk("rw_wdata", bus.pmem_wdata,   0);
        chk("rw_dresp", bus.d_resp,       0);
        chk("rw_err",   bus.arb_error,    0);
        rst = 1'b0;
        tick();

        // pmem_error sets the sticky flag without starting anything
        bus.pmem_error = 1'b1;
        tick();
        bus.pmem_error = 1'b0;
        chk("pe_err_set", bus.arb_error,  1);
        chk("pe_write",   bus.pmem_write, 0);
        tick();
        chk("pe_err_held", bus.arb_error, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
